// File: rtl/regfile_read_unit_pkg.sv
// Shared sizing constants for the register-file read unit.
package regfile_read_unit_pkg;

  // Default register count; must be a power of two.
  localparam int REGFILE_NUM_REGS = 16;

  // Address width that selects one of the default registers.
  localparam int REGFILE_ADDR_W = $clog2(REGFILE_NUM_REGS);

  // Register 0 is hardwired to zero and never reserved.
  localparam int ZERO_REG = 0;

endpackage : regfile_read_unit_pkg

// File: rtl/register_32.sv
// Single storage register with synchronous clear and a write strobe.
module register_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             write,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] read_data
);

  logic [WIDTH-1:0] value_d;
  logic [WIDTH-1:0] value_q;

  // Next value: load on write, otherwise hold.
  always_comb begin
    value_d = value_q;
    if (write) begin
      value_d = write_data;
    end
  end

  // Clear has priority over any write in the same cycle.
  always_ff @(posedge clock) begin
    if (clear) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign read_data = value_q;

endmodule : register_32

// File: rtl/regfile_read_unit.sv
// Register-file read side: operand reads with busy-bit stalls and writeback forwarding.
module regfile_read_unit
  import regfile_read_unit_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int NUM_REGS = REGFILE_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              WriteEn,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [ADDR_W-1:0] ReqRA,
  input  logic [ADDR_W-1:0] ReqRB,
  input  logic [ADDR_W-1:0] ReqRD,
  input  logic              ReqDestEn,
  output logic              RespValid,
  output logic [WIDTH-1:0]  RespA,
  output logic [WIDTH-1:0]  RespB
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [WIDTH-1:0]    reg_vals [NUM_REGS];
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] busy_q;
  logic                stall_a;
  logic                stall_b;
  logic                stall_d;
  logic                accept;
  logic [WIDTH-1:0]    operand_a;
  logic [WIDTH-1:0]    operand_b;
  logic                resp_valid_d;
  logic                resp_valid_q;
  logic [WIDTH-1:0]    resp_a_d;
  logic [WIDTH-1:0]    resp_a_q;
  logic [WIDTH-1:0]    resp_b_d;
  logic [WIDTH-1:0]    resp_b_q;

  // Register 0 has no storage and always reads zero.
  assign reg_vals[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
    register_32 #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clock     (Clock),
      .clear     (Clear),
      .write     (WriteEn && (WriteAddr == ADDR_W'(i))),
      .write_data(WriteData),
      .read_data (reg_vals[i])
    );
  end

  // A busy register only blocks if this cycle's writeback does not resolve it.
  always_comb begin
    stall_a = busy_q[ReqRA] && !(WriteEn && (WriteAddr == ReqRA));
    stall_b = busy_q[ReqRB] && !(WriteEn && (WriteAddr == ReqRB));
    stall_d = ReqDestEn && busy_q[ReqRD] && !(WriteEn && (WriteAddr == ReqRD));
  end

  assign ReqReady = !(stall_a || stall_b || stall_d);
  assign accept   = ReqValid && ReqReady;

  // Operand select: zero register, then writeback bypass, then stored value.
  always_comb begin
    operand_a = reg_vals[ReqRA];
    if (ReqRA == ZERO_ADDR) begin
      operand_a = '0;
    end else if (WriteEn && (WriteAddr == ReqRA)) begin
      operand_a = WriteData;
    end
    operand_b = reg_vals[ReqRB];
    if (ReqRB == ZERO_ADDR) begin
      operand_b = '0;
    end else if (WriteEn && (WriteAddr == ReqRB)) begin
      operand_b = WriteData;
    end
  end

  // Scoreboard update: writeback clears, a new reservation sets and wins over the clear.
  always_comb begin
    busy_d = busy_q;
    if (WriteEn) begin
      busy_d[WriteAddr] = 1'b0;
    end
    if (accept && ReqDestEn && (ReqRD != ZERO_ADDR)) begin
      busy_d[ReqRD] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // Response registers load on accept and otherwise hold their last operands.
  always_comb begin
    resp_valid_d = accept;
    resp_a_d     = resp_a_q;
    resp_b_d     = resp_b_q;
    if (accept) begin
      resp_a_d = operand_a;
      resp_b_d = operand_b;
    end
  end

  // Scoreboard and response state with synchronous clear.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      busy_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_a_q     <= '0;
      resp_b_q     <= '0;
    end else begin
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_a_q     <= resp_a_d;
      resp_b_q     <= resp_b_d;
    end
  end

  assign RespValid = resp_valid_q;
  assign RespA     = resp_a_q;
  assign RespB     = resp_b_q;

endmodule : regfile_read_unit
